// File: rtl/cursa_pkg.sv
// ---------------------------------------------------------------------------
// cursa_pkg : shared state encoding, default timing and target helper | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cursa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_LOCKOUT = 2'b10,
    ST_DONE    = 2'b11
  } stare_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned LOCKOUT_CYCLES_DEF  = 1000;

  // A zero target or a non-BCD digit means an unlimited race.
  function automatic logic target_valid(input logic [3:0] units, input logic [3:0] tens);
    return (units <= 4'd9) && (tens <= 4'd9) && ({tens, units} != 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_linie.sv
// ---------------------------------------------------------------------------
// debounce_linie : line sensor synchronizer, debouncer and crossing strobe | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_linie #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic crossing_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q;

  // The last accepted high sample sets the level; any low sample drops it.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (!sync_q[1]) begin
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      level_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
    end
  end

  assign crossing_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/control_cursa.sv
// ---------------------------------------------------------------------------
// control_cursa : race controller driving an external BCD lap counter | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module control_cursa
  import cursa_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
  input  logic       tact,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       line_sensor,
  input  logic [3:0] target_unitati,
  input  logic [3:0] target_zeci,
  input  logic [3:0] cifra_unitati,
  input  logic [3:0] cifra_zeci,
  output logic       lap_pulse,
  output logic       count_clear,
  output logic       motor_en,
  output logic       race_done,
  output logic [1:0] stare
);

  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  stare_e        state_q;
  logic [LW-1:0] lock_q;
  logic [3:0]    tgt_u_q, tgt_z_q;
  logic          lap_pulse_q, count_clear_q, motor_en_q, race_done_q;
  logic          crossing;
  logic          target_hit;

  debounce_linie #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i     (tact),
    .rst_ni    (reset),
    .line_i    (line_sensor),
    .crossing_o(crossing)
  );

  assign target_hit = target_valid(tgt_u_q, tgt_z_q) &&
                      ({cifra_zeci, cifra_unitati} == {tgt_z_q, tgt_u_q});

  always_ff @(posedge tact or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      lock_q        <= '0;
      tgt_u_q       <= 4'h0;
      tgt_z_q       <= 4'h0;
      lap_pulse_q   <= 1'b0;
      count_clear_q <= 1'b0;
      motor_en_q    <= 1'b0;
      race_done_q   <= 1'b0;
    end else begin
      lap_pulse_q   <= 1'b0;
      count_clear_q <= 1'b0;
      // stop overrides everything, including a simultaneous start or crossing
      if (stop) begin
        state_q     <= ST_IDLE;
        motor_en_q  <= 1'b0;
        race_done_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              count_clear_q <= 1'b1;
              tgt_u_q       <= target_unitati;
              tgt_z_q       <= target_zeci;
              state_q       <= ST_RUN;
              motor_en_q    <= 1'b1;
              race_done_q   <= 1'b0;
            end
          end
          ST_RUN: begin
            if (crossing) begin
              lap_pulse_q <= 1'b1;
              lock_q      <= LOCK_LOAD;
              state_q     <= ST_LOCKOUT;
            end
          end
          ST_LOCKOUT: begin
            if (target_hit) begin
              state_q     <= ST_DONE;
              motor_en_q  <= 1'b0;
              race_done_q <= 1'b1;
            end else if (lock_q == '0) begin
              state_q <= ST_RUN;
            end else begin
              lock_q <= lock_q - 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign lap_pulse   = lap_pulse_q;
  assign count_clear = count_clear_q;
  assign motor_en    = motor_en_q;
  assign race_done   = race_done_q;
  assign stare       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_control_cursa.sv
// ---------------------------------------------------------------------------
// tb_control_cursa : directed vector bench for control_cursa | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_control_cursa;

  logic       tact = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       line_sensor = 1'b0;
  logic [3:0] target_unitati = 4'd0;
  logic [3:0] target_zeci = 4'd0;
  logic [3:0] cifra_unitati;
  logic [3:0] cifra_zeci;
  logic       lap_pulse, count_clear, motor_en, race_done;
  logic [1:0] stare;

  int vectors = 0;
  int errors  = 0;

  control_cursa #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (10)
  ) dut (
    .tact          (tact),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .line_sensor   (line_sensor),
    .target_unitati(target_unitati),
    .target_zeci   (target_zeci),
    .cifra_unitati (cifra_unitati),
    .cifra_zeci    (cifra_zeci),
    .lap_pulse     (lap_pulse),
    .count_clear   (count_clear),
    .motor_en      (motor_en),
    .race_done     (race_done),
    .stare         (stare)
  );

  always #5 tact = ~tact;

  // External BCD lap counter: clocked by lap_pulse, cleared by count_clear.
  logic [3:0] cnt_u = 4'd0;
  logic [3:0] cnt_z = 4'd0;
  always @(posedge lap_pulse or posedge count_clear) begin
    if (count_clear) begin
      cnt_u <= 4'd0;
      cnt_z <= 4'd0;
    end else if (cnt_u == 4'd9) begin
      cnt_u <= 4'd0;
      cnt_z <= (cnt_z == 4'd9) ? 4'd0 : cnt_z + 4'd1;
    end else begin
      cnt_u <= cnt_u + 4'd1;
    end
  end
  assign cifra_unitati = cnt_u;
  assign cifra_zeci    = cnt_z;

  typedef struct {
    logic [3:0] tu;
    logic [3:0] tz;
    logic       s;
    logic       p;
    logic       l;
    int         n;
    logic       lp;
    logic       cc;
    logic       me;
    logic       rd;
    logic [1:0] st;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t mk(input int tu, input int tz, input int s, input int p,
                              input int l, input int n, input int lp, input int cc,
                              input int me, input int rd, input int st);
    vec_t v;
    v.tu = 4'(tu); v.tz = 4'(tz); v.s = 1'(s); v.p = 1'(p); v.l = 1'(l); v.n = n;
    v.lp = 1'(lp); v.cc = 1'(cc); v.me = 1'(me); v.rd = 1'(rd); v.st = 2'(st);
    return v;
  endfunction

  task automatic step(input logic s, input logic p, input logic l);
    start = s;
    stop = p;
    line_sensor = l;
    @(posedge tact);
    #1;
  endtask

  task automatic chk(input string nm, input logic lp, input logic cc, input logic me,
                     input logic rd, input logic [1:0] st);
    vectors++;
    if (lap_pulse !== lp || count_clear !== cc || motor_en !== me ||
        race_done !== rd || stare !== st) begin
      errors++;
      $display("FAIL %s: got lp=%b cc=%b me=%b rd=%b st=%b, expected lp=%b cc=%b me=%b rd=%b st=%b",
               nm, lap_pulse, count_clear, motor_en, race_done, stare, lp, cc, me, rd, st);
    end
  endtask

  // One debounced crossing from RUN: lap pulse on the 7th edge, then 10 cycles of lockout.
  task automatic lap_and_lockout(input string nm);
    for (int i = 0; i < 4; i++) begin step(1'b0, 1'b0, 1'b1); chk(nm, 0, 0, 1, 0, 2'b01); end
    for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0, 1'b0); chk(nm, 0, 0, 1, 0, 2'b01); end
    step(1'b0, 1'b0, 1'b0); chk({nm, "_lap"}, 1, 0, 1, 0, 2'b10);
    for (int i = 0; i < 9; i++) begin step(1'b0, 1'b0, 1'b0); chk({nm, "_lock"}, 0, 0, 1, 0, 2'b10); end
    step(1'b0, 1'b0, 1'b0); chk({nm, "_rerun"}, 0, 0, 1, 0, 2'b01);
  endtask

  initial begin
    //            tu  tz  s  p  l  n   lp cc me rd st
    tbl[0]  = mk(3,  0,  0, 0, 0, 2,  0, 0, 0, 0, 0);  // idle
    tbl[1]  = mk(3,  0,  1, 1, 0, 1,  0, 0, 0, 0, 0);  // start+stop: stop wins
    tbl[2]  = mk(3,  0,  1, 0, 0, 1,  0, 1, 1, 0, 1);  // start, target 03 latched
    tbl[3]  = mk(1,  0,  0, 0, 0, 2,  0, 0, 1, 0, 1);  // later target change ignored
    tbl[4]  = mk(1,  0,  0, 0, 1, 3,  0, 0, 1, 0, 1);  // 3-cycle glitch
    tbl[5]  = mk(1,  0,  0, 0, 0, 6,  0, 0, 1, 0, 1);
    tbl[6]  = mk(1,  0,  0, 0, 1, 4,  0, 0, 1, 0, 1);  // crossing 1
    tbl[7]  = mk(1,  0,  0, 0, 0, 2,  0, 0, 1, 0, 1);
    tbl[8]  = mk(1,  0,  0, 0, 0, 1,  1, 0, 1, 0, 2);  // lap 1 at k+6
    tbl[9]  = mk(1,  0,  0, 0, 1, 4,  0, 0, 1, 0, 2);  // crossing inside lockout
    tbl[10] = mk(1,  0,  0, 0, 0, 5,  0, 0, 1, 0, 2);
    tbl[11] = mk(1,  0,  0, 0, 1, 1,  0, 0, 1, 0, 1);  // lockout expired
    tbl[12] = mk(1,  0,  0, 0, 1, 3,  0, 0, 1, 0, 1);
    tbl[13] = mk(1,  0,  0, 0, 0, 2,  0, 0, 1, 0, 1);
    tbl[14] = mk(1,  0,  0, 0, 0, 1,  1, 0, 1, 0, 2);  // lap 2
    tbl[15] = mk(1,  0,  0, 0, 0, 9,  0, 0, 1, 0, 2);
    tbl[16] = mk(1,  0,  0, 0, 0, 1,  0, 0, 1, 0, 1);
    tbl[17] = mk(1,  0,  0, 0, 1, 4,  0, 0, 1, 0, 1);
    tbl[18] = mk(1,  0,  0, 0, 0, 2,  0, 0, 1, 0, 1);
    tbl[19] = mk(1,  0,  0, 0, 0, 1,  1, 0, 1, 0, 2);  // lap 3
    tbl[20] = mk(1,  0,  0, 0, 0, 1,  0, 0, 0, 1, 3);  // count 03 reached
    tbl[21] = mk(1,  0,  0, 0, 0, 2,  0, 0, 0, 1, 3);
    tbl[22] = mk(2,  0,  1, 0, 0, 1,  0, 1, 1, 0, 1);  // restart from DONE
    tbl[23] = mk(2,  0,  0, 0, 0, 1,  0, 0, 1, 0, 1);
    tbl[24] = mk(2,  0,  0, 0, 1, 4,  0, 0, 1, 0, 1);
    tbl[25] = mk(2,  0,  0, 0, 0, 2,  0, 0, 1, 0, 1);
    tbl[26] = mk(2,  0,  0, 1, 0, 1,  0, 0, 0, 0, 0);  // stop with coincident crossing
    tbl[27] = mk(2,  0,  0, 0, 0, 2,  0, 0, 0, 0, 0);

    repeat (3) @(posedge tact);
    #1;
    chk("reset_state", 0, 0, 0, 0, 2'b00);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        target_unitati = tbl[i].tu;
        target_zeci    = tbl[i].tz;
        step(tbl[i].s, tbl[i].p, tbl[i].l);
        chk($sformatf("row%0d_c%0d", i, c), tbl[i].lp, tbl[i].cc, tbl[i].me, tbl[i].rd, tbl[i].st);
      end
    end

    // Invalid target 1A: twelve laps, never DONE.
    target_zeci    = 4'd1;
    target_unitati = 4'hA;
    step(1'b1, 1'b0, 1'b0); chk("unl_start", 0, 1, 1, 0, 2'b01);
    target_zeci    = 4'd0;
    target_unitati = 4'd1;
    for (int n = 0; n < 12; n++) lap_and_lockout($sformatf("unl%0d", n));
    vectors++;
    if (cnt_z !== 4'd1 || cnt_u !== 4'd2) begin
      errors++;
      $display("FAIL unl_laps: got count %h%h, expected 12", cnt_z, cnt_u);
    end

    // Asynchronous reset in the middle of LOCKOUT.
    lap_and_lockout("pre_rst");
    for (int i = 0; i < 4; i++) begin step(1'b0, 1'b0, 1'b1); chk("pre_rst2", 0, 0, 1, 0, 2'b01); end
    for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0, 1'b0); chk("pre_rst2", 0, 0, 1, 0, 2'b01); end
    step(1'b0, 1'b0, 1'b0); chk("pre_rst2_lap", 1, 0, 1, 0, 2'b10);
    step(1'b0, 1'b0, 1'b1); chk("pre_rst2_lock", 0, 0, 1, 0, 2'b10);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", 0, 0, 0, 0, 2'b00);
    line_sensor = 1'b0;
    @(posedge tact);
    #1;
    chk("rst_held", 0, 0, 0, 0, 2'b00);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin step(1'b0, 1'b0, 1'b0); chk("post_rst", 0, 0, 0, 0, 2'b00); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_cursa.md
CONTROL_CURSA -- requirements
Module: control_cursa

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles needed to accept a line crossing.
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 1000: cycles after a counted lap during which crossings are ignored.
REQ-003 SHALL have port tact  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start  input  1  synchronous level; begin or restart a race.
REQ-006 SHALL have port stop  input  1  synchronous level; abort the race.
REQ-007 SHALL have port line_sensor  input  1  raw, asynchronous start/finish-line detector.
REQ-008 SHALL have port target_unitati  input  4  BCD target laps, units digit.
REQ-009 SHALL have port target_zeci  input  4  BCD target laps, tens digit.
REQ-010 SHALL have port cifra_unitati  input  4  current lap count units digit, returned from the lap counter.
REQ-011 SHALL have port cifra_zeci  input  4  current lap count tens digit, returned from the lap counter.
REQ-012 SHALL have port lap_pulse  output  1  one-cycle registered pulse; drives the lap counter clock.
REQ-013 SHALL have port count_clear  output  1  one-cycle active-high registered pulse; drives the lap counter reset.
REQ-014 SHALL have port motor_en  output  1  registered; 1 = car drives.
REQ-015 SHALL have port race_done  output  1  registered; 1 = target laps completed.
REQ-016 SHALL have port stare  output  2  current state encoding.

Function
REQ-017 line_sensor SHALL pass through a 2-flop synchronizer before any use.
REQ-018 Debounced level SHALL go high after DEBOUNCE_CYCLES consecutive high synchronized samples and low on the first low sample; a crossing is its rising edge.
REQ-019 First high line_sensor sample at edge k SHALL yield lap_pulse high after edge k+DEBOUNCE_CYCLES+2, for exactly one cycle, when in RUN.
REQ-020 States: IDLE=00, RUN=01, LOCKOUT=10, DONE=11.
REQ-021 IDLE: motor_en=0; start=1 -> count_clear=1 one cycle, latch targets, go RUN.
REQ-022 RUN: motor_en=1; crossing -> lap_pulse, load lockout counter with LOCKOUT_CYCLES-1, go LOCKOUT.
REQ-023 LOCKOUT: motor_en=1; crossings ignored; counter decrements each cycle; at 0 -> RUN.
REQ-024 In LOCKOUT, when {cifra_zeci,cifra_unitati} equals latched nonzero target -> DONE immediately, regardless of lockout count.
REQ-025 DONE: motor_en=0, race_done=1; start=1 -> count_clear, relatch targets, RUN, race_done=0.
REQ-026 stop=1 in RUN, LOCKOUT or DONE SHALL go IDLE next edge, motor_en=0, race_done=0, lap count NOT cleared.
REQ-027 start and stop both 1 in the same cycle: stop wins.
REQ-028 Target 00, or either target digit >9, SHALL mean unlimited: never enter DONE; counter wrap 99->00 ignored.
REQ-029 Targets SHALL be sampled only on the start transition; later changes have no effect.
REQ-030 A crossing coincident with stop SHALL produce no lap_pulse.

Reset
REQ-031 reset=0 SHALL immediately force stare=IDLE, lap_pulse=0, count_clear=0, motor_en=0, race_done=0, clear synchronizer, debounce, lockout and target registers.
REQ-032 Reset asserted mid-race SHALL discard any pending crossing; no lap_pulse after release without a new crossing.

Structure
REQ-033 Package cursa_pkg SHALL hold the state encoding and default DEBOUNCE_CYCLES/LOCKOUT_CYCLES.
REQ-034 Sub-module debounce_linie SHALL contain synchronizer, debounce counter and rising-edge detector, output one-cycle crossing strobe.
REQ-035 The lap counter SHALL remain external; control_cursa only drives lap_pulse/count_clear and reads the digits.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10)
REQ-036 start in IDLE -> count_clear one cycle, stare=01, motor_en=1 next edge.
REQ-037 line_sensor high 3 cycles -> no lap_pulse; high 4 cycles from edge k -> single lap_pulse after edge k+6.
REQ-038 Second crossing 5 cycles after first lap_pulse -> ignored; third crossing 15 cycles after -> counted.
REQ-039 Target 03, three spaced crossings -> after third, stare=11, race_done=1, motor_en=0.
REQ-040 start=stop=1 in IDLE -> stays IDLE, no count_clear; target 1A then 12 crossings -> never DONE; reset=0 in LOCKOUT -> all outputs 0 at once.
